ram_1r4w: RTL and testbench
===========================

# ram_1R4W

Four-write, one-read 32-bit memory built from four internal 1R1W banks plus a Live Value Table (LVT). Each write port owns one bank. The LVT records, per address, which port wrote last, and the read path returns that bank's word. It is the write-side counterpart of the replicated multi-read RAM family and is used where several producers update a shared table that a single consumer reads.

## Interface
- BLOCKSIZE, 10, address MSB index; address width is BLOCKSIZE+1, depth is 2^(BLOCKSIZE+1) words
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- w_addr_1..w_addr_4  input  BLOCKSIZE+1  write address, port n
- w_din_1..w_din_4  input  32  write data, port n
- w_enb_1..w_enb_4  input  1  write enable, port n, active-high
- r_addr_1  input  BLOCKSIZE+1  read address
- r_enb_1  input  1  read request, active-high
- r_dout_1  output  32  read data, registered
- r_valid_1  output  1  high for one cycle when r_dout_1 carries data for a request
- w_conflict  output  1  registered; high one cycle after two or more enabled write ports hit the same address

## Operation
- Storage: bank n (n=1..4), 2^(BLOCKSIZE+1) x 32, written only by port n. Bank contents are not reset.
- LVT: 2^(BLOCKSIZE+1) x 2 bits. On posedge, for each enabled port n: bank n[w_addr_n] <= w_din_n, and LVT[w_addr_n] <= n-1.
- Same-address multi-write in one cycle: the lowest-numbered enabled port wins the LVT entry. Losing ports still write their own banks, but their data is unreachable. w_conflict asserts the next cycle.
- Read: on posedge with r_enb_1=1, sel = LVT[r_addr_1] and bank word = bank(sel+1)[r_addr_1] are both sampled from pre-edge state. Then r_dout_1 <= that word and r_valid_1 <= 1.
- With r_enb_1=0: r_valid_1 <= 0 and r_dout_1 holds its last value.
- Reset (rst=0, asynchronous): all LVT entries <= 0, r_dout_1 <= 0, r_valid_1 <= 0, w_conflict <= 0. Writes and reads are ignored while rst=0.
- Reset mid-operation: pending read data is discarded (r_valid_1 forced 0). Bank contents survive, but the LVT points every address at bank 1. Data written by ports 2–4 before reset is therefore lost.
- A read of an address never written since reset returns bank 1 contents, which are undefined. The bench must not check it.

## Timing
- Write: committed at the posedge where w_enb_n=1. Visible to a read issued at the following posedge or later.
- Read latency: 1 cycle. Request at edge k gives r_dout_1/r_valid_1 valid after edge k. Reads may issue every cycle (full throughput).
- Same-cycle read and write to the same address: behaviour depends on the macro below.
- w_conflict: asserted after edge k for a conflicting write at edge k; deasserted the next cycle unless the conflict repeats.
- Address wrap: none; addresses are full-range, with no out-of-range case.

## Configuration
- RAM_1R4W_BYPASS_EN defined: a same-cycle read/write to the same address returns the new data of the winning write port, i.e. write-first with the lowest-index port priority.
- RAM_1R4W_BYPASS_EN undefined: read-first; the returned data is the word stored before that edge, selected by the old LVT entry.
- Either way, write behaviour, the LVT update and latency are identical.

## Test plan
- Reset, then port 3 writes 0xDEADBEEF to addr 5 and port 1 writes 0x11111111 to addr 6 in the same cycle. Read 5 then 6 in back-to-back cycles → r_dout_1 = 0xDEADBEEF then 0x11111111, with r_valid_1 high on both cycles.
- Overwrite ordering: port 2 writes 0xA to addr 9, next cycle port 4 writes 0xB to addr 9, then read 9 → 0x0000000B, w_conflict stays 0.
- Conflict: ports 2, 3 and 4 all write addr 0x7FF in one cycle with 0x2, 0x3 and 0x4 → w_conflict = 1 for exactly one cycle, and a later read of 0x7FF returns 0x00000002.
- Same-cycle read/write: addr 12 holds 0x55, and port 1 writes 0x66 to addr 12 while a read of 12 is issued → returns 0x66 with RAM_1R4W_BYPASS_EN, 0x55 without it.
- Reset mid-stream: issue a read, assert rst=0 before the next edge → r_valid_1 = 0 and r_dout_1 = 0 immediately. After release, port 1 writes 0x77 to addr 3 and a read of 3 returns 0x77.
- Idle read: r_enb_1 = 0 for 3 cycles after a read returns 0x1234 → r_valid_1 = 0 and r_dout_1 holds 0x1234.

Source files
------------

// File: rtl/ram_1r4w.sv
// ram_1r4w
//   Four-write, one-read 32-bit memory. Each write port owns a private
//   1R1W bank; a Live Value Table (LVT) remembers, per address, which port
//   wrote last, and the read path returns that bank's word.
//
// Ports
//   clk                 single clock, all state updates on posedge
//   rst                 asynchronous, active-low reset
//   w_addr_n / w_din_n / w_enb_n   write port n (n = 1..4)
//   r_addr_1, r_enb_1   read request
//   r_dout_1            registered read data, holds when no read is issued
//   r_valid_1           high for one cycle when r_dout_1 carries read data
//   w_conflict          registered; high after an edge where two or more
//                       enabled write ports hit the same address
//
// Configuration
//   RAM_1R4W_BYPASS_EN  defined: same-cycle read/write to one address
//                       returns the winning (lowest-index) port's new data.
//                       undefined: read-first, returns the pre-edge word.

module ram_1r4w #(
    parameter int BLOCKSIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BLOCKSIZE:0]   w_addr_1,
    input  logic [BLOCKSIZE:0]   w_addr_2,
    input  logic [BLOCKSIZE:0]   w_addr_3,
    input  logic [BLOCKSIZE:0]   w_addr_4,
    input  logic [31:0]          w_din_1,
    input  logic [31:0]          w_din_2,
    input  logic [31:0]          w_din_3,
    input  logic [31:0]          w_din_4,
    input  logic                 w_enb_1,
    input  logic                 w_enb_2,
    input  logic                 w_enb_3,
    input  logic                 w_enb_4,
    input  logic [BLOCKSIZE:0]   r_addr_1,
    input  logic                 r_enb_1,
    output logic [31:0]          r_dout_1,
    output logic                 r_valid_1,
    output logic                 w_conflict
);

    localparam int          AW    = BLOCKSIZE + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic [31:0] bank1 [DEPTH];
    logic [31:0] bank2 [DEPTH];
    logic [31:0] bank3 [DEPTH];
    logic [31:0] bank4 [DEPTH];
    logic [1:0]  lvt   [DEPTH];

    logic [1:0]  rd_sel;
    logic [31:0] rd_word;
    logic        conflict_now;

    // Banks are never cleared; reset only blocks writes while it is held.
    always_ff @(posedge clk or negedge rst) begin
        if (rst) begin
            if (w_enb_1) bank1[w_addr_1] <= w_din_1;
            if (w_enb_2) bank2[w_addr_2] <= w_din_2;
            if (w_enb_3) bank3[w_addr_3] <= w_din_3;
            if (w_enb_4) bank4[w_addr_4] <= w_din_4;
        end
    end

    // Highest port is written first so the lowest-numbered enabled port's
    // nonblocking update lands last and owns a contested LVT entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                lvt[i[AW-1:0]] <= '0;
            end
        end else begin
            if (w_enb_4) lvt[w_addr_4] <= 2'd3;
            if (w_enb_3) lvt[w_addr_3] <= 2'd2;
            if (w_enb_2) lvt[w_addr_2] <= 2'd1;
            if (w_enb_1) lvt[w_addr_1] <= 2'd0;
        end
    end

    always_comb begin
        rd_sel  = lvt[r_addr_1];
        rd_word = '0;
        unique case (rd_sel)
            2'd0: rd_word = bank1[r_addr_1];
            2'd1: rd_word = bank2[r_addr_1];
            2'd2: rd_word = bank3[r_addr_1];
            2'd3: rd_word = bank4[r_addr_1];
            default: rd_word = '0;
        endcase
`ifdef RAM_1R4W_BYPASS_EN
        // Checked from port 4 down to port 1 so the lowest hitting port wins.
        if (w_enb_4 && (w_addr_4 == r_addr_1)) rd_word = w_din_4;
        if (w_enb_3 && (w_addr_3 == r_addr_1)) rd_word = w_din_3;
        if (w_enb_2 && (w_addr_2 == r_addr_1)) rd_word = w_din_2;
        if (w_enb_1 && (w_addr_1 == r_addr_1)) rd_word = w_din_1;
`endif
    end

    always_comb begin
        conflict_now = (w_enb_1 && w_enb_2 && (w_addr_1 == w_addr_2))
                     | (w_enb_1 && w_enb_3 && (w_addr_1 == w_addr_3))
                     | (w_enb_1 && w_enb_4 && (w_addr_1 == w_addr_4))
                     | (w_enb_2 && w_enb_3 && (w_addr_2 == w_addr_3))
                     | (w_enb_2 && w_enb_4 && (w_addr_2 == w_addr_4))
                     | (w_enb_3 && w_enb_4 && (w_addr_3 == w_addr_4));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout_1   <= '0;
            r_valid_1  <= 1'b0;
            w_conflict <= 1'b0;
        end else begin
            r_valid_1  <= r_enb_1;
            w_conflict <= conflict_now;
            if (r_enb_1) r_dout_1 <= rd_word;
        end
    end

endmodule

// File: tb/tb_ram_1r4w.sv
// tb_ram_1r4w
//   Self-checking bench for ram_1r4w: a table of directed vectors, a
//   hand-written reset-mid-stream sequence, and a randomized phase checked
//   against a last-value-per-address reference model.

module tb_ram_1r4w;

`ifdef RAM_1R4W_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [3:0]        we;
    logic [3:0][10:0]  wa;
    logic [3:0][31:0]  wd;
    logic              re;
    logic [10:0]       ra;
    logic [31:0]       r_dout_1;
    logic              r_valid_1;
    logic              w_conflict;

    int n_checks = 0;
    int n_pass   = 0;

    ram_1r4w #(.BLOCKSIZE(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .w_addr_1   (wa[0]),
        .w_addr_2   (wa[1]),
        .w_addr_3   (wa[2]),
        .w_addr_4   (wa[3]),
        .w_din_1    (wd[0]),
        .w_din_2    (wd[1]),
        .w_din_3    (wd[2]),
        .w_din_4    (wd[3]),
        .w_enb_1    (we[0]),
        .w_enb_2    (we[1]),
        .w_enb_3    (we[2]),
        .w_enb_4    (we[3]),
        .r_addr_1   (ra),
        .r_enb_1    (re),
        .r_dout_1   (r_dout_1),
        .r_valid_1  (r_valid_1),
        .w_conflict (w_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       we;
        logic [3:0][10:0] wa;
        logic [3:0][31:0] wd;
        logic             re;
        logic [10:0]      ra;
        logic             exp_valid;
        logic [31:0]      exp_dout;
        logic             exp_conf;
    } vec_t;

    function automatic vec_t mkv(input logic [3:0] w,
                                 input logic [10:0] a1, input logic [10:0] a2,
                                 input logic [10:0] a3, input logic [10:0] a4,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] d3, input logic [31:0] d4,
                                 input logic r, input logic [10:0] radr,
                                 input logic ev, input logic [31:0] ed,
                                 input logic ec);
        vec_t v;
        v.we = w;
        v.wa[0] = a1; v.wa[1] = a2; v.wa[2] = a3; v.wa[3] = a4;
        v.wd[0] = d1; v.wd[1] = d2; v.wd[2] = d3; v.wd[3] = d4;
        v.re = r; v.ra = radr;
        v.exp_valid = ev; v.exp_dout = ed; v.exp_conf = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic idle_inputs();
        we = '0; wa = '0; wd = '0; re = 1'b0; ra = '0;
    endtask

    // Reference model: the value an address logically holds (last winning
    // write), and whether it has been written since the last reset.
    logic [31:0] mem   [2048];
    bit          known [2048];

    vec_t vt [17];

    initial begin
        logic [31:0] exp_dout;
        bit          exp_dout_known;
        logic        exp_conf;
        logic        hit;
        logic [31:0] hit_data;

        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(r_valid_1), 32'h0);
        chk("reset_dout", r_dout_1, 32'h0);
        chk("reset_conflict", 32'(w_conflict), 32'h0);
        rst = 1'b1;

        vt[0]  = mkv(4'b0101, 11'd6, 11'd0, 11'd5, 11'd0, 32'h11111111, 0, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0, 0);
        vt[1]  = mkv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11'd5, 1, 32'hDEADBEEF, 0);
        vt[2]  = mkv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11'd6, 1, 32'h11111111, 0);
        vt[3]  = mkv(4'b0010, 0, 11'd9, 0, 0, 0, 32'hA, 0, 0, 0, 0, 0, 32'h11111111, 0);
        vt[4]  = mkv(4'b1000, 0, 0, 0, 11'd9, 0, 0, 0, 32'hB, 0, 0, 0, 32'h11111111, 0);
        vt[5]  = mkv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11'd9, 1, 32'hB, 0);
        vt[6]  = mkv(4'b1110, 0, 11'h7FF, 11'h7FF, 11'h7FF, 0, 32'h2, 32'h3, 32'h4, 0, 0, 0, 32'hB, 1);
        vt[7]  = mkv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11'h7FF, 1, 32'h2, 0);
        vt[8]  = mkv(4'b0001, 11'd12, 0, 0, 0, 32'h55, 0, 0, 0, 0, 0, 0, 32'h2, 0);
        vt[9]  = mkv(4'b0001, 11'd12, 0, 0, 0, 32'h66, 0, 0, 0, 1, 11'd12, 1, BYP ? 32'h66 : 32'h55, 0);
        vt[10] = mkv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11'd12, 1, 32'h66, 0);
        vt[11] = mkv(4'b0011, 11'd20, 11'd21, 11'd20, 0, 32'h1234, 32'h99, 32'h77, 0, 0, 0, 0, 32'h66, 0);
        vt[12] = mkv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11'd20, 1, 32'h1234, 0);
        vt[13] = mkv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'd21, 0, 32'h1234, 0);
        vt[14] = mkv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'd21, 0, 32'h1234, 0);
        vt[15] = mkv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'd21, 0, 32'h1234, 0);
        vt[16] = mkv(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11'd21, 1, 32'h99, 0);

        for (int i = 0; i < 17; i++) begin
            we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd;
            re = vt[i].re; ra = vt[i].ra;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(r_valid_1), 32'(vt[i].exp_valid));
            chk($sformatf("vec%0d_conflict", i), 32'(w_conflict), 32'(vt[i].exp_conf));
            chk($sformatf("vec%0d_dout", i), r_dout_1, vt[i].exp_dout);
        end

        // Reset between a read issue and its edge discards the read.
        idle_inputs();
        re = 1'b1; ra = 11'd21;
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(r_valid_1), 32'h0);
        chk("midrst_dout", r_dout_1, 32'h0);
        we = 4'b0001; wa[0] = 11'd3; wd[0] = 32'h5A5A5A5A;
        @(posedge clk);
        #1;
        chk("inrst_valid", 32'(r_valid_1), 32'h0);
        chk("inrst_dout", r_dout_1, 32'h0);
        rst = 1'b1;
        idle_inputs();
        we = 4'b0001; wa[0] = 11'd3; wd[0] = 32'h77;
        @(posedge clk);
        #1;
        idle_inputs();
        re = 1'b1; ra = 11'd3;
        @(posedge clk);
        #1;
        chk("postrst_valid", 32'(r_valid_1), 32'h1);
        chk("postrst_dout", r_dout_1, 32'h77);
        idle_inputs();

        // Randomized phase against the reference model.
        rst = 1'b0;
        #2;
        rst = 1'b1;
        for (int a = 0; a < 2048; a++) known[a] = 1'b0;
        exp_dout = '0;
        exp_dout_known = 1'b1;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 4; p++) begin
                we[p] = ($urandom_range(0, 1) == 1);
                wa[p] = 11'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 11'h7F0 : 11'h0);
                wd[p] = $urandom;
            end
            re = ($urandom_range(0, 3) != 0);
            ra = 11'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 11'h7F0 : 11'h0);

            exp_conf = 1'b0;
            for (int p = 0; p < 4; p++)
                for (int q = p + 1; q < 4; q++)
                    if (we[p] && we[q] && wa[p] == wa[q]) exp_conf = 1'b1;

            hit = 1'b0;
            hit_data = '0;
            for (int p = 3; p >= 0; p--)
                if (we[p] && wa[p] == ra) begin hit = 1'b1; hit_data = wd[p]; end

            if (re) begin
                if (BYP && hit) begin
                    exp_dout = hit_data; exp_dout_known = 1'b1;
                end else begin
                    exp_dout = mem[ra]; exp_dout_known = known[ra];
                end
            end

            for (int p = 3; p >= 0; p--)
                if (we[p]) begin mem[wa[p]] = wd[p]; known[wa[p]] = 1'b1; end

            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d_valid", c), 32'(r_valid_1), 32'(re));
            chk($sformatf("rnd%0d_conflict", c), 32'(w_conflict), 32'(exp_conf));
            if (exp_dout_known)
                chk($sformatf("rnd%0d_dout", c), r_dout_1, exp_dout);
        end

        idle_inputs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
